// File: rtl/execute_cc_stage.sv
// Y86-64 execute-stage back end: condition-code register, branch/cmov condition
// evaluation and the E->M pipeline register with stall/bubble control.
module execute_cc_stage #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] alu_a,
  input  logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_out,
  input  logic [W-1:0] e_valA,
  input  logic [3:0]   e_dstE_in,
  input  logic [3:0]   e_dstM,
  input  logic [2:0]   e_stat,
  input  logic         set_cc_en,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic         e_cnd,
  output logic [3:0]   e_dstE,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic [3:0]   M_icode,
  output logic [3:0]   M_ifun,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic [2:0]   M_stat
);

  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] REG_NONE     = 4'hF;
  localparam logic [3:0] IFUN_ZERO    = 4'h0;
  localparam logic [2:0] STAT_AOK     = 3'd1;

  logic         zf_r, sf_r, of_r;
  logic         zf_next_s, sf_next_s, of_next_s;
  logic         a_sign_s, b_sign_s, o_sign_s;
  logic         cnd_s;
  logic [3:0]   dst_e_s;
  logic         cc_load_s;
  logic [3:0]   m_icode_r, m_ifun_r, m_dst_e_r, m_dst_m_r;
  logic         m_cnd_r;
  logic [W-1:0] m_val_e_r, m_val_a_r;
  logic [2:0]   m_stat_r;
  logic         unused_operand_bits_s;

  // Overflow only looks at operand/result sign bits; the rest are deliberately ignored.
  assign unused_operand_bits_s = ^{alu_a[W-2:0], alu_b[W-2:0]};

  assign a_sign_s  = alu_a[W-1];
  assign b_sign_s  = alu_b[W-1];
  assign o_sign_s  = alu_out[W-1];
  assign cc_load_s = (e_icode == ICODE_OPQ) && set_cc_en;

  // Next condition-code values derived from the current ALU result.
  always_comb begin
    zf_next_s = (alu_out == {W{1'b0}});
    sf_next_s = o_sign_s;
    of_next_s = 1'b0;
    case (e_ifun)
      4'h0:    of_next_s = (a_sign_s == b_sign_s) && (o_sign_s != a_sign_s);
      4'h1:    of_next_s = (a_sign_s != b_sign_s) && (o_sign_s != b_sign_s);
      default: of_next_s = 1'b0;
    endcase
  end

  // Condition-code register; independent of the M-stage stall/bubble controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_r <= 1'b1;
      sf_r <= 1'b0;
      of_r <= 1'b0;
    end else if (cc_load_s) begin
      zf_r <= zf_next_s;
      sf_r <= sf_next_s;
      of_r <= of_next_s;
    end else begin
      zf_r <= zf_r;
      sf_r <= sf_r;
      of_r <= of_r;
    end
  end

  // Branch/cmov condition from the registered flags.
  always_comb begin
    cnd_s = 1'b0;
    case (e_ifun)
      4'h0:    cnd_s = 1'b1;
      4'h1:    cnd_s = (sf_r ^ of_r) | zf_r;
      4'h2:    cnd_s = sf_r ^ of_r;
      4'h3:    cnd_s = zf_r;
      4'h4:    cnd_s = ~zf_r;
      4'h5:    cnd_s = ~(sf_r ^ of_r);
      4'h6:    cnd_s = ~(sf_r ^ of_r) & ~zf_r;
      default: cnd_s = 1'b0;
    endcase
  end

  // A failed cmov writes no register.
  always_comb begin
    if ((e_icode == ICODE_CMOVXX) && !cnd_s) begin
      dst_e_s = REG_NONE;
    end else begin
      dst_e_s = e_dstE_in;
    end
  end

  // E->M pipeline register: bubble beats stall, stall beats load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || M_bubble) begin
      m_icode_r <= ICODE_NOP;
      m_ifun_r  <= IFUN_ZERO;
      m_cnd_r   <= 1'b0;
      m_val_e_r <= {W{1'b0}};
      m_val_a_r <= {W{1'b0}};
      m_dst_e_r <= REG_NONE;
      m_dst_m_r <= REG_NONE;
      m_stat_r  <= STAT_AOK;
    end else if (M_stall) begin
      m_icode_r <= m_icode_r;
      m_ifun_r  <= m_ifun_r;
      m_cnd_r   <= m_cnd_r;
      m_val_e_r <= m_val_e_r;
      m_val_a_r <= m_val_a_r;
      m_dst_e_r <= m_dst_e_r;
      m_dst_m_r <= m_dst_m_r;
      m_stat_r  <= m_stat_r;
    end else begin
      m_icode_r <= e_icode;
      m_ifun_r  <= e_ifun;
      m_cnd_r   <= cnd_s;
      m_val_e_r <= alu_out;
      m_val_a_r <= e_valA;
      m_dst_e_r <= dst_e_s;
      m_dst_m_r <= e_dstM;
      m_stat_r  <= e_stat;
    end
  end

  assign e_cnd   = cnd_s;
  assign e_dstE  = dst_e_s;
  assign cc_zf   = zf_r;
  assign cc_sf   = sf_r;
  assign cc_of   = of_r;
  assign M_icode = m_icode_r;
  assign M_ifun  = m_ifun_r;
  assign M_cnd   = m_cnd_r;
  assign M_valE  = m_val_e_r;
  assign M_valA  = m_val_a_r;
  assign M_dstE  = m_dst_e_r;
  assign M_dstM  = m_dst_m_r;
  assign M_stat  = m_stat_r;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Directed table-driven bench for execute_cc_stage plus hand-written stall,
// bubble and asynchronous reset sequences.
module tb_execute_cc_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  e_icode, e_ifun, e_dstE_in, e_dstM;
  logic [63:0] alu_a, alu_b, alu_out, e_valA;
  logic [2:0]  e_stat;
  logic        set_cc_en, M_stall, M_bubble;
  logic        e_cnd, cc_zf, cc_sf, cc_of, M_cnd;
  logic [3:0]  e_dstE, M_icode, M_ifun, M_dstE, M_dstM;
  logic [63:0] M_valE, M_valA;
  logic [2:0]  M_stat;

  int n_tests = 0;
  int n_fail  = 0;

  execute_cc_stage #(.W(64)) dut (
    .clk(clk), .rst(rst), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .e_valA(e_valA),
    .e_dstE_in(e_dstE_in), .e_dstM(e_dstM), .e_stat(e_stat),
    .set_cc_en(set_cc_en), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_cnd(e_cnd), .e_dstE(e_dstE), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .M_icode(M_icode), .M_ifun(M_ifun), .M_cnd(M_cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun;
    logic [63:0] a, b, out, val_a;
    logic [3:0]  dste_in, dstm;
    logic [2:0]  stat;
    logic        set_cc, bubble;
    logic        exp_cnd;
    logic [3:0]  exp_dste;
    logic        exp_zf, exp_sf, exp_of;
    logic [3:0]  exp_m_icode;
    logic        exp_m_cnd;
    logic [63:0] exp_m_vale;
    logic [3:0]  exp_m_dste;
  } vec_t;

  localparam logic [63:0] MAXP  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] FFFE  = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] DEAD  = 64'hDEAD_BEEF_0000_1234;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] out,
                       input logic [63:0] va, input logic [3:0] dste, input logic [3:0] dstm,
                       input logic [2:0] stat, input logic scc, input logic stall,
                       input logic bubble);
    e_icode = icode; e_ifun = ifun; alu_a = a; alu_b = b; alu_out = out;
    e_valA = va; e_dstE_in = dste; e_dstM = dstm; e_stat = stat;
    set_cc_en = scc; M_stall = stall; M_bubble = bubble;
  endtask

  task automatic chk_m(input string tag, input logic [3:0] icode, input logic [3:0] ifun,
                       input logic cnd, input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] dste, input logic [3:0] dstm, input logic [2:0] stat);
    chk({tag, " M_icode"}, {60'd0, M_icode}, {60'd0, icode});
    chk({tag, " M_ifun"},  {60'd0, M_ifun},  {60'd0, ifun});
    chk({tag, " M_cnd"},   {63'd0, M_cnd},   {63'd0, cnd});
    chk({tag, " M_valE"},  M_valE, ve);
    chk({tag, " M_valA"},  M_valA, va);
    chk({tag, " M_dstE"},  {60'd0, M_dstE},  {60'd0, dste});
    chk({tag, " M_dstM"},  {60'd0, M_dstM},  {60'd0, dstm});
    chk({tag, " M_stat"},  {61'd0, M_stat},  {61'd0, stat});
  endtask

  task automatic chk_cc(input string tag, input logic zf, input logic sf, input logic of);
    chk({tag, " ZF"}, {63'd0, cc_zf}, {63'd0, zf});
    chk({tag, " SF"}, {63'd0, cc_sf}, {63'd0, sf});
    chk({tag, " OF"}, {63'd0, cc_of}, {63'd0, of});
  endtask

  initial begin
    //          icode ifun a     b      out    valA   dEi   dM    st  scc bub cnd dE    zf sf of mic mcnd mvalE  mdE
    vecs[0]  = '{4'h6, 4'h0, MAXP, MAXP, FFFE, 64'h11, 4'h2, 4'hF, 3'd1, 1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 4'h6, 1'b1, FFFE, 4'h2};
    vecs[1]  = '{4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'h22, 4'hF, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 64'd0, 4'hF};
    vecs[2]  = '{4'h7, 4'h6, 64'd0, 64'd0, 64'd5, 64'h33, 4'hF, 4'hF, 3'd1, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1, 64'd5, 4'hF};
    vecs[3]  = '{4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 64'h44, 4'h4, 4'hF, 3'd1, 1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 4'h6, 1'b1, 64'd0, 4'h4};
    vecs[4]  = '{4'h6, 4'h3, DEAD, DEAD, 64'd0, 64'h55, 4'h5, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0, 64'd0, 4'h5};
    vecs[5]  = '{4'h2, 4'h4, 64'd0, 64'h77, 64'h77, 64'h66, 4'h3, 4'hF, 3'd4, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 64'h77, 4'hF};
    vecs[6]  = '{4'h2, 4'h3, 64'd0, 64'h88, 64'h88, 64'h77, 4'h3, 4'hF, 3'd3, 1'b1, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 4'h2, 1'b1, 64'h88, 4'h3};
    vecs[7]  = '{4'h6, 4'h1, 64'd1, MINN, MAXP, 64'h0, 4'h6, 4'hF, 3'd1, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h6, 1'b1, MAXP, 4'h6};
    vecs[8]  = '{4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'h99, 4'hF, 4'hF, 3'd1, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 4'h7, 1'b1, 64'd0, 4'hF};
    vecs[9]  = '{4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 64'h9A, 4'hF, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 64'd0, 4'hF};
    vecs[10] = '{4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 64'h9B, 4'hF, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 64'd0, 4'hF};
    vecs[11] = '{4'h6, 4'h1, 64'd5, 64'd3, FFFE, 64'h1, 4'h7, 4'hF, 3'd1, 1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 4'h6, 1'b1, FFFE, 4'h7};
    vecs[12] = '{4'h6, 4'h2, MINN, MINN, MINN, 64'h2, 4'h8, 4'hF, 3'd1, 1'b1, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 4'h6, 1'b1, MINN, 4'h8};
    vecs[13] = '{4'h6, 4'h5, MINN, MINN, 64'd0, 64'h3, 4'h9, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0, 64'd0, 4'h9};
    vecs[14] = '{4'h6, 4'h0, 64'd0, 64'd0, 64'h10, 64'hAB, 4'h2, 4'h3, 3'd1, 1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 64'd0, 4'hF};

    rst = 1'b1;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0);
    #2;
    chk_cc("reset", 1'b1, 1'b0, 1'b0);
    chk_m("reset", 4'h1, 4'h0, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].val_a,
            vecs[i].dste_in, vecs[i].dstm, vecs[i].stat, vecs[i].set_cc, 1'b0, vecs[i].bubble);
      #1;
      chk($sformatf("v%0d e_cnd", i), {63'd0, e_cnd}, {63'd0, vecs[i].exp_cnd});
      chk($sformatf("v%0d e_dstE", i), {60'd0, e_dstE}, {60'd0, vecs[i].exp_dste});
      @(posedge clk); #1;
      chk_cc($sformatf("v%0d", i), vecs[i].exp_zf, vecs[i].exp_sf, vecs[i].exp_of);
      chk_m($sformatf("v%0d", i), vecs[i].exp_m_icode,
            vecs[i].bubble ? 4'h0 : vecs[i].ifun, vecs[i].exp_m_cnd, vecs[i].exp_m_vale,
            vecs[i].bubble ? 64'd0 : vecs[i].val_a, vecs[i].exp_m_dste,
            vecs[i].bubble ? 4'hF : vecs[i].dstm, vecs[i].bubble ? 3'd1 : vecs[i].stat);
    end

    // Load, then stall two cycles while inputs change; flags still update.
    drive(4'h7, 4'h0, 64'd0, 64'd0, 64'hAAAA, 64'hBBBB, 4'h4, 4'h5, 3'd2, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_m("load", 4'h7, 4'h0, 1'b1, 64'hAAAA, 64'hBBBB, 4'h4, 4'h5, 3'd2);
    for (int k = 0; k < 2; k++) begin
      drive(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 64'h100 + 64'(k), 4'h1, 4'h2, 3'd3, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk_m($sformatf("stall%0d", k), 4'h7, 4'h0, 1'b1, 64'hAAAA, 64'hBBBB, 4'h4, 4'h5, 3'd2);
    end
    chk_cc("cc during stall", 1'b1, 1'b0, 1'b0);

    drive(4'h6, 4'h1, 64'd0, 64'd0, 64'h5, 64'h200, 4'h1, 4'h2, 3'd3, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk_m("stall+bubble", 4'h1, 4'h0, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1);

    // Asynchronous reset mid-cycle discards state before any clock edge.
    drive(4'h6, 4'h0, 64'd0, 64'd0, MINN, 64'h300, 4'h2, 4'h6, 3'd3, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_cc("pre-reset", 1'b0, 1'b1, 1'b1);
    chk("pre-reset M_icode", {60'd0, M_icode}, 64'd6);
    #2;
    rst = 1'b1;
    #1;
    chk_cc("async reset", 1'b1, 1'b0, 1'b0);
    chk_m("async reset", 4'h1, 4'h0, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_cc_stage.md
# execute_cc_stage

Execute-stage back end of the Y86-64 pipeline. Consumes the ALU result, including the 64-bit XOR path, along with the ALU operands. It maintains the architectural condition-code register (ZF/SF/OF) and evaluates the branch/cmov condition `e_cnd`. It also owns the E→M pipeline register that feeds the memory stage, with stall/bubble control driven by pipeline control logic.

## Interface
- `W`, 64, datapath width (ALU operands/result, valA, valE)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `e_icode`  in  4  instruction code in E (NOP=1, HALT=0, CMOVXX=2, OPQ=6, JXX=7)
- `e_ifun`  in  4  function code in E
- `alu_a`, `alu_b`  in  W  ALU operands aluA, aluB
- `alu_out`  in  W  ALU result: add = B+A, sub = B−A, and = B&A, xor = B^A
- `e_valA`  in  W  valA passed to memory stage
- `e_dstE_in`, `e_dstM`  in  4  destination registers (0xF = none)
- `e_stat`  in  3  status (AOK=1, HLT=2, ADR=3, INS=4)
- `set_cc_en`  in  1  from control; 0 when an exception is in M or W
- `M_stall`, `M_bubble`  in  1  pipeline-register control
- `e_cnd`  out  1  combinational condition result
- `e_dstE`  out  4  combinational effective dstE (for forwarding)
- `cc_zf`, `cc_sf`, `cc_of`  out  1  registered condition codes
- `M_icode`, `M_ifun`  out  4  registered
- `M_cnd`  out  1  registered
- `M_valE`, `M_valA`  out  W  registered
- `M_dstE`, `M_dstM`  out  4  registered
- `M_stat`  out  3  registered

## Operation
- CC update occurs at the clock edge only when `e_icode`==6 and `set_cc_en`==1.
  - ZF = (`alu_out`==0).
  - SF = `alu_out`[W-1].
  - OF is evaluated on sign bits only, no extra width:
    - add (ifun 0): OF = (a==b) & (out≠a).
    - sub (ifun 1): OF = (a≠b) & (out≠b).
    - and/xor (ifun 2/3): OF = 0.
  - For any other ifun, OF = 0 while ZF/SF update normally.
- `e_cnd` is combinational from the registered CC and `e_ifun`:
  - 0 always → 1
  - 1 le → (SF^OF)|ZF
  - 2 l → SF^OF
  - 3 e → ZF
  - 4 ne → ~ZF
  - 5 ge → ~(SF^OF)
  - 6 g → ~(SF^OF)&~ZF
  - other ifun → 0
- `e_cnd` is meaningful for icode 2 and 7 only. For all other icodes it still follows the table; consumers must ignore it.
- `e_dstE` = 0xF when `e_icode`==2 and `e_cnd`==0; otherwise `e_dstE_in`.
- The pipeline register captures `alu_out`→`M_valE`, `e_valA`, `e_dstE`, `e_dstM`, `e_icode`, `e_ifun`, `e_cnd`, and `e_stat`.
- The pipeline register has three actions, in priority order:
  - `M_bubble`=1 → load bubble: icode=1, ifun=0, cnd=0, valE=0, valA=0, dstE=dstM=0xF, stat=1.
  - else `M_stall`=1 → hold all fields.
  - else → load.
- `M_bubble` has priority over `M_stall` when both are asserted.
- CC update is independent of `M_stall`/`M_bubble`. It is gated only by `set_cc_en` and icode.

## Timing
- Reset (async, immediate, independent of clk):
  - ZF=1, SF=0, OF=0.
  - M register = bubble values: icode=1, ifun=0, cnd=0, valE=0, valA=0, dstE=dstM=0xF, stat=1.
- Release of `rst` takes effect at the first rising edge with `rst`=0.
- A reset asserted mid-operation discards in-flight contents.
- Latency, E inputs → M outputs: 1 cycle.
- Latency, `e_cnd`/`e_dstE`: 0 cycles (combinational).
- New CC values are visible 1 cycle after the OPq is in E. An OPq immediately followed by a jXX/cmovXX in E uses the updated flags.
- Outputs must not glitch on reset deassertion. No combinational path exists from `M_*` inputs to `e_*` outputs.

## Test plan
- **Reset:** assert `rst` mid-cycle → ZF=1, SF=0, OF=0, `M_icode`=1, `M_dstE`=0xF, `M_stat`=1 immediately, before any clock edge.
- **Add overflow:** icode=6, ifun=0, a=b=0x7FFF_FFFF_FFFF_FFFF, out=0xFFFF_FFFF_FFFF_FFFE, `set_cc_en`=1 → next cycle ZF=0, SF=1, OF=1; `M_valE`=0xFFFF_FFFF_FFFF_FFFE.
- **XOR to zero:** icode=6, ifun=3, a=b=0xDEAD_BEEF_0000_1234, out=0 → ZF=1, SF=0, OF=0. Then apply cmovne (icode 2, ifun 4, `e_dstE_in`=3) → `e_cnd`=0, `e_dstE`=0xF, `M_dstE`=0xF.
- **CC gating:**
  - icode=6 with `set_cc_en`=0 → flags unchanged.
  - icode=7 with `set_cc_en`=1 → flags unchanged.
- **Stall/bubble:**
  - Load a value, then hold `M_stall`=1 for 2 cycles while inputs change → M outputs constant.
  - `M_stall`=`M_bubble`=1 → bubble loaded.
- **Sub overflow/jl:** ifun=1, a=1, b=0x8000_0000_0000_0000, out=0x7FFF_FFFF_FFFF_FFFF → OF=1, SF=0. Next cycle, jl (icode 7, ifun 2) → `e_cnd`=1.
